// File: rtl/seg_time_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_time_display_pkg
// Purpose  : Font, digit-index and clamp constants for the MM.SS display.
// Revision : 1.0 - initial release
// ============================================================================
package seg_time_display_pkg;

  // Active-low {dp,g,f,e,d,c,b,a}; dp off (bit 7 high) in every glyph.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;

  function automatic logic [7:0] seg_font(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_font = SEG_0;
      4'd1:    seg_font = SEG_1;
      4'd2:    seg_font = SEG_2;
      4'd3:    seg_font = SEG_3;
      4'd4:    seg_font = SEG_4;
      4'd5:    seg_font = SEG_5;
      4'd6:    seg_font = SEG_6;
      4'd7:    seg_font = SEG_7;
      4'd8:    seg_font = SEG_8;
      4'd9:    seg_font = SEG_9;
      default: seg_font = SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_time_display_bin2dec6.sv
`default_nettype none
// ============================================================================
// Module   : bin2dec6
// Purpose  : Clamp a 6-bit binary value to MAX_VAL and split it into BCD
//            tens/ones digits. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module bin2dec6
  import seg_time_display_pkg::*;
#(
  parameter logic [5:0] MAX_VAL = MAX_SEC
) (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] w_clamped;

  assign w_clamped = (bin > MAX_VAL) ? MAX_VAL : bin;

  // Threshold ladder instead of a divider: the range is only 0..59.
  always_comb begin
    tens = 4'd0;
    ones = w_clamped[3:0];
    if (w_clamped >= 6'd50) begin
      tens = 4'd5;
      ones = 4'(w_clamped - 6'd50);
    end else if (w_clamped >= 6'd40) begin
      tens = 4'd4;
      ones = 4'(w_clamped - 6'd40);
    end else if (w_clamped >= 6'd30) begin
      tens = 4'd3;
      ones = 4'(w_clamped - 6'd30);
    end else if (w_clamped >= 6'd20) begin
      tens = 4'd2;
      ones = 4'(w_clamped - 6'd20);
    end else if (w_clamped >= 6'd10) begin
      tens = 4'd1;
      ones = 4'(w_clamped - 6'd10);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_time_display.sv
`default_nettype none
// ============================================================================
// Module   : seg_time_display
// Purpose  : Shows the active song's MM.SS on a 4-digit common-anode display,
//            blinking while paused.
// Revision : 1.0 - initial release
// ============================================================================
module seg_time_display
  import seg_time_display_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       song_sel,
  input  logic       sound_off,
  input  logic [5:0] mins1,
  input  logic [5:0] secs1,
  input  logic [5:0] mins2,
  input  logic [5:0] secs2,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [11:0]        w_sel_val;
  logic [11:0]        r_cand;
  logic [11:0]        r_snap;
  logic [3:0]         w_min_tens, w_min_ones, w_sec_tens, w_sec_ones;
  logic [3:0]         w_digit;
  logic [7:0]         w_seg_nxt;
  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [1:0]         r_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_on;
  logic               r_sound_d;
  logic               w_sound_rise;
  logic               w_blink_on_nxt;
  logic               w_visible;

  assign w_sel_val = song_sel ? {mins2, secs2} : {mins1, secs1};

  bin2dec6 #(.MAX_VAL(MAX_MIN)) u_bin_min (
    .bin  (r_snap[11:6]),
    .tens (w_min_tens),
    .ones (w_min_ones)
  );

  bin2dec6 #(.MAX_VAL(MAX_SEC)) u_bin_sec (
    .bin  (r_snap[5:0]),
    .tens (w_sec_tens),
    .ones (w_sec_ones)
  );

  always_comb begin
    w_digit = w_sec_ones;
    case (r_idx)
      DIG_SEC_ONES: w_digit = w_sec_ones;
      DIG_SEC_TENS: w_digit = w_sec_tens;
      DIG_MIN_ONES: w_digit = w_min_ones;
      DIG_MIN_TENS: w_digit = w_min_tens;
      default:      w_digit = w_sec_ones;
    endcase
    w_seg_nxt = seg_font(w_digit);
    if (r_idx == DIG_MIN_ONES) begin
      w_seg_nxt[7] = 1'b0;
    end
  end

  assign w_sound_rise = sound_off & ~r_sound_d;

  // Output gating uses the post-edge blink phase so a fresh pause is visible
  // for exactly one full half-period.
  always_comb begin
    w_blink_on_nxt = r_blink_on;
    if (w_sound_rise) begin
      w_blink_on_nxt = 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      w_blink_on_nxt = ~r_blink_on;
    end
  end

  assign w_visible = ~sound_off | w_blink_on_nxt;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_cand      <= '0;
      r_snap      <= '0;
      r_scan_cnt  <= '0;
      r_idx       <= 2'd0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_sound_d   <= 1'b0;
      an          <= 4'hF;
      seg         <= SEG_BLANK;
    end else begin
      r_cand <= w_sel_val;
      if (w_sel_val == r_cand) begin
        r_snap <= r_cand;
      end

      if (r_scan_cnt == SCAN_LAST) begin
        r_scan_cnt <= '0;
        r_idx      <= r_idx + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end

      r_sound_d  <= sound_off;
      r_blink_on <= w_blink_on_nxt;
      if (w_sound_rise || (r_blink_cnt == BLINK_LAST)) begin
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end

      if (w_visible) begin
        an  <= ~(4'b0001 << r_idx);
        seg <= w_seg_nxt;
      end else begin
        an  <= 4'hF;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_time_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_time_display
// Purpose  : Scoreboard bench for seg_time_display (SCAN_DIV=4, BLINK_DIV=20).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_time_display;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       song_sel = 1'b0;
  logic       sound_off = 1'b0;
  logic [5:0] mins1 = '0, secs1 = '0, mins2 = '0, secs2 = '0;
  logic [7:0] seg;
  logic [3:0] an;

  seg_time_display #(.CLK_HZ(1000), .SCAN_HZ(250), .BLINK_HZ(25)) dut (
    .clk       (clk),
    .RESET     (RESET),
    .song_sel  (song_sel),
    .sound_off (sound_off),
    .mins1     (mins1),
    .secs1     (secs1),
    .mins2     (mins2),
    .secs2     (secs2),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  int         edge_cnt = 0;
  logic [3:0] exp_d [4];
  bit         paused = 1'b0;
  int         pcnt = 0;

  function automatic logic [7:0] font(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
    exp_d[3] = d3; exp_d[2] = d2; exp_d[1] = d1; exp_d[0] = d0;
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] s, input string name);
    exp_t e;
    e.an = a; e.seg = s; e.name = name;
    sb_q.push_back(e);
  endtask

  // One expectation per clock edge, derived from edges since reset release.
  task automatic step(input int n, input string name);
    int  idx;
    bit  vis;
    logic [7:0] s;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_cnt++;
      idx = ((edge_cnt - 1) / 4) % 4;
      vis = 1'b1;
      if (paused) begin
        vis = ((pcnt / 20) % 2) == 0;
        pcnt++;
      end
      if (vis) begin
        s = font(exp_d[idx]);
        if (idx == 2) s[7] = 1'b0;
        push(~(4'b0001 << idx), s, name);
      end else begin
        push(4'hF, 8'hFF, name);
      end
    end
  endtask

  task automatic step_fixed(input int n, input logic [3:0] a, input logic [7:0] s,
                            input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      push(a, s, name);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if (an !== e.an || seg !== e.seg) begin
          n_fail++;
          $display("FAIL %s @%0t: an=%b seg=%h, expected an=%b seg=%h",
                   e.name, $time, an, seg, e.an, e.seg);
        end
      end
    end
  end

  initial begin : stim
    set_digits(0, 0, 0, 0);

    // Reset held, then release and watch idx advance every 4 cycles.
    step_fixed(3, 4'hF, 8'hFF, "reset_hold");
    @(negedge clk); RESET = 1'b0; edge_cnt = 0;
    step(16, "reset_scan");

    // 12:34 on song 1.
    @(negedge clk); mins1 = 6'd12; secs1 = 6'd34;
    step(2, "digits_latency");
    set_digits(1, 2, 3, 4);
    step(16, "digits_1234");

    // Switch to song 2 = 05:07.
    @(negedge clk); mins2 = 6'd5; secs2 = 6'd7;
    step(1, "song2_preload");
    @(negedge clk); song_sel = 1'b1;
    step(2, "song_sel_latency");
    set_digits(0, 5, 0, 7);
    step(16, "song2_0507");

    // Pause: 20 visible, 20 blank, 20 visible; then resume.
    @(negedge clk); sound_off = 1'b1; paused = 1'b1; pcnt = 0;
    step(60, "blink");
    @(negedge clk); sound_off = 1'b0; paused = 1'b0;
    step(8, "unpause");
    // A second pause must restart the blink phase from visible.
    @(negedge clk); sound_off = 1'b1; paused = 1'b1; pcnt = 0;
    step(25, "blink_restart");
    @(negedge clk); sound_off = 1'b0; paused = 1'b0;
    step(4, "unpause2");

    // Back to song 1 with an out-of-range second value.
    @(negedge clk); song_sel = 1'b0; secs1 = 6'd63;
    step(2, "clamp_latency");
    set_digits(1, 2, 5, 9);
    step(16, "clamp_1259");

    // Value changing every cycle never reaches the display.
    for (int t = 0; t < 11; t++) begin
      @(negedge clk); secs1 = (t % 2 == 0) ? 6'd10 : 6'd11;
      step(1, "filter_toggle");
    end
    @(negedge clk); secs1 = 6'd11;
    step(2, "filter_hold_latency");
    set_digits(1, 2, 1, 1);
    step(16, "filter_1211");

    // Advance to the first cycle showing idx=2, then reset between edges.
    for (int k = 0; k < 16 && (((edge_cnt - 1) % 16) != 8); k++) begin
      step(1, "pre_async");
    end
    @(negedge clk);
    #1 RESET = 1'b1;
    #1 push(4'hF, 8'hFF, "async_reset");
    ->sample_ev;
    step_fixed(2, 4'hF, 8'hFF, "async_reset_hold");
    @(negedge clk); RESET = 1'b0; edge_cnt = 0;
    set_digits(0, 0, 0, 0);
    step(2, "post_reset_zero");
    set_digits(1, 2, 1, 1);
    step(14, "post_reset_scan");

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
